// File: rtl/timer_bus_pkg.sv
// Shared definitions for the timer register-port arbiter: register map,
// FSM state encoding and the register address decode.
package timer_bus_pkg;

    localparam logic [63:0] TMR_ADDR   = 64'd0;
    localparam logic [63:0] TVAL_ADDR  = 64'd4;
    localparam logic [63:0] TCONF_ADDR = 64'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    // Exact match against the three implemented timer registers.
    function automatic logic addr_valid(input logic [63:0] addr);
        return (addr == TMR_ADDR) || (addr == TVAL_ADDR) || (addr == TCONF_ADDR);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last granted
// requester and wraps; the pointer register is owned by the caller.
module rr_arbiter #(
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int unsigned pos;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            pos = (32'(last_i) + off) % NREQ;
            if (!valid_o && req_i[IDX_W'(pos)]) begin
                valid_o                = 1'b1;
                idx_o                  = IDX_W'(pos);
                gnt_o[IDX_W'(pos)]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_bus_arbiter.sv
// Shares the timer register port between NREQ requesters: round-robin
// grant, one rd/wr pulse per transaction, registered read data and ack/err.
module timer_bus_arbiter
    import timer_bus_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_bi,
    input  logic [NREQ-1:0]          we_bi,
    input  logic [NREQ*ADDR_W-1:0]   addr_bi,
    input  logic [NREQ*DATA_W-1:0]   data_bi,
    output logic [NREQ-1:0]          gnt_bo,
    output logic [NREQ-1:0]          ack_bo,
    output logic                     err_bo,
    output logic [DATA_W-1:0]        rdata_bo,
    output logic                     busy_o,
    output logic [ADDR_W-1:0]        t_addr_bo,
    output logic [DATA_W-1:0]        t_data_bo,
    output logic                     t_rd_o,
    output logic                     t_wr_o,
    input  logic [DATA_W-1:0]        t_data_bi
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic                we_q, we_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   t_addr_q, t_addr_d;
    logic [DATA_W-1:0]   t_data_q, t_data_d;
    logic                t_rd_q, t_rd_d;
    logic                t_wr_q, t_wr_d;

    logic [NREQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_we;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i   (req_bi),
        .last_i  (last_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Mux out the winning requester's command fields.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (arb_idx == IDX_W'(k)) begin
                sel_addr = addr_bi[k*ADDR_W +: ADDR_W];
                sel_data = data_bi[k*DATA_W +: DATA_W];
                sel_we   = we_bi[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= IDX_W'(NREQ - 1);
            winner_q <= '0;
            we_q     <= 1'b0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            t_addr_q <= '0;
            t_data_q <= '0;
            t_rd_q   <= 1'b0;
            t_wr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            we_q     <= we_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            t_addr_q <= t_addr_d;
            t_data_q <= t_data_d;
            t_rd_q   <= t_rd_d;
            t_wr_q   <= t_wr_d;
        end
    end

    // Outputs are computed one state ahead so each lands registered in the
    // cycle it belongs to (strobes in ISSUE, ack/err in ACK).
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        winner_d = winner_q;
        we_d     = we_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        t_addr_d = t_addr_q;
        t_data_d = t_data_q;
        t_rd_d   = 1'b0;
        t_wr_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    winner_d = arb_idx;
                    we_d     = sel_we;
                    gnt_d    = arb_gnt;
                    if (addr_valid(64'(sel_addr))) begin
                        state_d  = ST_ISSUE;
                        t_addr_d = sel_addr;
                        t_data_d = sel_data;
                        t_wr_d   = sel_we;
                        t_rd_d   = !sel_we;
                    end else begin
                        state_d = ST_ACK;
                        ack_d   = arb_gnt;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_ACK;
                    ack_d   = gnt_q;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rdata_d = t_data_bi;
                ack_d   = gnt_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                gnt_d   = '0;
                last_d  = winner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign gnt_bo    = gnt_q;
    assign ack_bo    = ack_q;
    assign err_bo    = err_q;
    assign rdata_bo  = rdata_q;
    assign busy_o    = busy_q;
    assign t_addr_bo = t_addr_q;
    assign t_data_bo = t_data_q;
    assign t_rd_o    = t_rd_q;
    assign t_wr_o    = t_wr_q;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Directed bench for timer_bus_arbiter with a small behavioural timer
// (TMR/TVAL/TCONF, registered read data) attached to its timer port.
module tb_timer_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_bi = '0;
    logic [1:0]  we_bi = '0;
    logic [25:0] addr_bi = '0;
    logic [63:0] data_bi = '0;
    logic [1:0]  gnt_bo, ack_bo;
    logic        err_bo, busy_o, t_rd_o, t_wr_o;
    logic [31:0] rdata_bo, t_data_bo, t_data_bi;
    logic [12:0] t_addr_bo;

    int total = 0;
    int bad   = 0;

    // Timer model: TCONF[0] enables counting, TVAL wraps to 0 after TMR.
    logic [31:0] tmr, tval, tconf;
    initial begin
        tmr = 0; tval = 0; tconf = 0; t_data_bi = 0;
    end
    always @(posedge clk) begin
        if (t_wr_o) begin
            case (t_addr_bo)
                13'd0: tmr <= t_data_bo;
                13'd4: tval <= t_data_bo;
                13'd8: tconf <= t_data_bo;
                default: ;
            endcase
        end else if (tconf[0]) begin
            tval <= (tval >= tmr) ? 32'd0 : tval + 32'd1;
        end
        if (t_rd_o)
            t_data_bi <= (t_addr_bo == 13'd0) ? tmr : (t_addr_bo == 13'd4) ? tval : tconf;
    end

    always #5 clk = ~clk;

    timer_bus_arbiter #(.NREQ(2), .ADDR_W(13), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_bi(req_bi), .we_bi(we_bi), .addr_bi(addr_bi),
        .data_bi(data_bi), .gnt_bo(gnt_bo), .ack_bo(ack_bo), .err_bo(err_bo),
        .rdata_bo(rdata_bo), .busy_o(busy_o), .t_addr_bo(t_addr_bo),
        .t_data_bo(t_data_bo), .t_rd_o(t_rd_o), .t_wr_o(t_wr_o), .t_data_bi(t_data_bi)
    );

    logic [1:0]  obs_ack[8], obs_gnt[8];
    logic        obs_wr[8], obs_rd[8], obs_err[8], obs_busy[8];
    logic [12:0] obs_addr[8];
    logic [31:0] obs_data[8], obs_rdata[8], obs_tval[8];
    int          ack_cyc;

    // Single-requester transaction; records per-cycle observations, cycle 0
    // being the first IDLE cycle that sees the request.
    task automatic run_txn(input int k, input logic we, input logic [12:0] a, input logic [31:0] d);
        for (int c = 0; c < 8; c++) begin
            obs_ack[c] = 'x; obs_gnt[c] = 'x; obs_wr[c] = 'x; obs_rd[c] = 'x;
            obs_err[c] = 'x; obs_busy[c] = 'x; obs_addr[c] = 'x; obs_data[c] = 'x;
            obs_rdata[c] = 'x; obs_tval[c] = 'x;
        end
        ack_cyc = -1;
        @(posedge clk); #1;
        req_bi[k] = 1'b1;
        we_bi[k]  = we;
        addr_bi[k*13 +: 13] = a;
        data_bi[k*32 +: 32] = d;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            obs_ack[c] = ack_bo; obs_gnt[c] = gnt_bo; obs_wr[c] = t_wr_o; obs_rd[c] = t_rd_o;
            obs_err[c] = err_bo; obs_busy[c] = busy_o; obs_addr[c] = t_addr_bo;
            obs_data[c] = t_data_bo; obs_rdata[c] = rdata_bo; obs_tval[c] = tval;
            if (ack_bo != 2'b00) begin
                ack_cyc = c;
                break;
            end
        end
        @(posedge clk); #1;
        req_bi[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (gnt_bo !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt_bo); end
        total++; if (ack_bo !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", ack_bo); end
        total++; if ({err_bo, busy_o, t_rd_o, t_wr_o} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {err_bo, busy_o, t_rd_o, t_wr_o}); end
        total++; if ({rdata_bo, t_data_bo, t_addr_bo} !== 77'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {rdata_bo, t_data_bo, t_addr_bo}); end
        rst = 1'b0;
    endtask

    task automatic test_write_tmr;
        run_txn(0, 1'b1, 13'd0, 32'd100);
        total++; if (ack_cyc !== 2) begin bad++; $display("FAIL wr_ack_cycle got=%0d exp=2", ack_cyc); end
        total++; if (obs_ack[2] !== 2'b01) begin bad++; $display("FAIL wr_ack got=%b exp=01", obs_ack[2]); end
        total++; if (obs_err[2] !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", obs_err[2]); end
        total++; if ({obs_wr[0], obs_wr[1], obs_wr[2]} !== 3'b010) begin bad++; $display("FAIL wr_pulse got=%b exp=010", {obs_wr[0], obs_wr[1], obs_wr[2]}); end
        total++; if ({obs_rd[0], obs_rd[1], obs_rd[2]} !== 3'b000) begin bad++; $display("FAIL wr_no_rd got=%b exp=000", {obs_rd[0], obs_rd[1], obs_rd[2]}); end
        total++; if (obs_addr[1] !== 13'd0 || obs_data[1] !== 32'd100) begin bad++; $display("FAIL wr_bus got=%0d/%0d exp=0/100", obs_addr[1], obs_data[1]); end
        total++; if ({obs_gnt[0], obs_gnt[1], obs_gnt[2]} !== 6'b000101) begin bad++; $display("FAIL wr_gnt got=%b exp=000101", {obs_gnt[0], obs_gnt[1], obs_gnt[2]}); end
        total++; if ({obs_busy[0], obs_busy[1], obs_busy[2]} !== 3'b011) begin bad++; $display("FAIL wr_busy got=%b exp=011", {obs_busy[0], obs_busy[1], obs_busy[2]}); end
        total++; if (tmr !== 32'd100) begin bad++; $display("FAIL wr_tmr got=%0d exp=100", tmr); end
    endtask

    task automatic test_read_back;
        run_txn(1, 1'b1, 13'd8, 32'd2);
        total++; if (ack_cyc !== 2 || obs_ack[2] !== 2'b10) begin bad++; $display("FAIL cfg_ack got=%0d/%b exp=2/10", ack_cyc, obs_ack[2]); end
        total++; if (tconf !== 32'd2) begin bad++; $display("FAIL cfg_tconf got=%0d exp=2", tconf); end
        run_txn(1, 1'b0, 13'd0, 32'd0);
        total++; if (ack_cyc !== 3) begin bad++; $display("FAIL rd_ack_cycle got=%0d exp=3", ack_cyc); end
        total++; if (obs_ack[3] !== 2'b10 || obs_err[3] !== 1'b0) begin bad++; $display("FAIL rd_ack got=%b/%b exp=10/0", obs_ack[3], obs_err[3]); end
        total++; if (obs_rdata[3] !== 32'd100) begin bad++; $display("FAIL rd_data got=%0d exp=100", obs_rdata[3]); end
        total++; if ({obs_rd[0], obs_rd[1], obs_rd[2], obs_rd[3]} !== 4'b0100) begin bad++; $display("FAIL rd_pulse got=%b exp=0100", {obs_rd[0], obs_rd[1], obs_rd[2], obs_rd[3]}); end
        total++; if ({obs_wr[1], obs_wr[2], obs_wr[3]} !== 3'b000) begin bad++; $display("FAIL rd_no_wr got=%b exp=000", {obs_wr[1], obs_wr[2], obs_wr[3]}); end
        total++; if (obs_gnt[3] !== 2'b10) begin bad++; $display("FAIL rd_gnt got=%b exp=10", obs_gnt[3]); end
    endtask

    task automatic test_invalid_addr;
        run_txn(0, 1'b0, 13'd12, 32'd0);
        total++; if (ack_cyc !== 1) begin bad++; $display("FAIL inv_ack_cycle got=%0d exp=1", ack_cyc); end
        total++; if (obs_ack[1] !== 2'b01 || obs_err[1] !== 1'b1) begin bad++; $display("FAIL inv_ack got=%b/%b exp=01/1", obs_ack[1], obs_err[1]); end
        total++; if ({obs_rd[0], obs_wr[0], obs_rd[1], obs_wr[1]} !== 4'b0000) begin bad++; $display("FAIL inv_no_access got=%b exp=0000", {obs_rd[0], obs_wr[0], obs_rd[1], obs_wr[1]}); end
        total++; if (obs_rdata[1] !== 32'd100) begin bad++; $display("FAIL inv_rdata_hold got=%0d exp=100", obs_rdata[1]); end
        @(negedge clk);
        total++; if (err_bo !== 1'b0 || ack_bo !== 2'b00 || gnt_bo !== 2'b00) begin bad++; $display("FAIL inv_after got=%b/%b/%b exp=0/00/00", err_bo, ack_bo, gnt_bo); end
    endtask

    task automatic test_tval_read;
        run_txn(0, 1'b1, 13'd8, 32'd1);
        run_txn(1, 1'b0, 13'd4, 32'd0);
        total++; if (ack_cyc !== 3) begin bad++; $display("FAIL tval_ack_cycle got=%0d exp=3", ack_cyc); end
        total++; if (obs_rdata[3] !== obs_tval[1]) begin bad++; $display("FAIL tval_data got=%0d exp=%0d", obs_rdata[3], obs_tval[1]); end
        total++; if (obs_rdata[3] > 32'd100) begin bad++; $display("FAIL tval_range got=%0d exp=0..100", obs_rdata[3]); end
        run_txn(0, 1'b1, 13'd8, 32'd0);
    endtask

    // Abort a read in WAIT, then both requesters stay high after release.
    task automatic test_reset_abort_and_alternate;
        logic [1:0] acks[4];
        logic [1:0] gnts[4];
        logic [31:0] rds[4];
        logic [1:0] first_gnt;
        int n;
        logic both;
        run_txn(0, 1'b0, 13'd0, 32'd0);
        @(posedge clk); #1;
        we_bi = 2'b00; addr_bi = '0; req_bi = 2'b11;
        @(posedge clk); @(posedge clk); #1;
        total++; if (gnt_bo !== 2'b10 || busy_o !== 1'b1) begin bad++; $display("FAIL abort_pre got=%b/%b exp=10/1", gnt_bo, busy_o); end
        rst = 1'b1;
        #1;
        total++; if ({gnt_bo, ack_bo, err_bo, busy_o, t_rd_o, t_wr_o} !== 8'd0) begin bad++; $display("FAIL abort_outs got=%b exp=0", {gnt_bo, ack_bo, err_bo, busy_o, t_rd_o, t_wr_o}); end
        total++; if ({rdata_bo, t_addr_bo, t_data_bo} !== 77'd0) begin bad++; $display("FAIL abort_data got=%h exp=0", {rdata_bo, t_addr_bo, t_data_bo}); end
        @(negedge clk);
        rst = 1'b0;
        n = 0; first_gnt = 2'b00; both = 1'b0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (t_rd_o && t_wr_o) both = 1'b1;
            if (first_gnt == 2'b00 && gnt_bo != 2'b00) first_gnt = gnt_bo;
            if (ack_bo != 2'b00) begin
                acks[n] = ack_bo; gnts[n] = gnt_bo; rds[n] = rdata_bo; n++;
            end
        end
        req_bi = 2'b00;
        total++; if (first_gnt !== 2'b01) begin bad++; $display("FAIL post_reset_first got=%b exp=01", first_gnt); end
        total++; if (n !== 4) begin bad++; $display("FAIL alt_count got=%0d exp=4", n); end
        if (n == 4) begin
            total++; if ({acks[0], acks[1], acks[2], acks[3]} !== 8'b01100110) begin bad++; $display("FAIL alt_acks got=%b exp=01100110", {acks[0], acks[1], acks[2], acks[3]}); end
            total++; if ({gnts[0], gnts[1], gnts[2], gnts[3]} !== 8'b01100110) begin bad++; $display("FAIL alt_gnts got=%b exp=01100110", {gnts[0], gnts[1], gnts[2], gnts[3]}); end
            total++; if (rds[0] !== 32'd100 || rds[3] !== 32'd100) begin bad++; $display("FAIL alt_rdata got=%0d/%0d exp=100/100", rds[0], rds[3]); end
        end
        total++; if (both !== 1'b0) begin bad++; $display("FAIL rd_wr_overlap got=%b exp=0", both); end
        repeat (4) @(negedge clk);
        total++; if (busy_o !== 1'b0 || gnt_bo !== 2'b00) begin bad++; $display("FAIL final_idle got=%b/%b exp=0/00", busy_o, gnt_bo); end
    endtask

    initial begin
        test_reset();
        test_write_tmr();
        test_read_back();
        test_invalid_addr();
        test_tval_read();
        test_reset_abort_and_alternate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_bus_arbiter.md
Name: timer_bus_arbiter

Overview:
Shares the single register port of the timer (addresses 0=TMR, 4=TVAL, 8=TCONF) between NREQ bus requesters, such as the CPU and a DMA/config engine. The block arbitrates round-robin, issues exactly one timer rd/wr pulse per transaction, captures read data from the timer's registered output, and returns ack/error to the winner. It sits between the requesters and the timer instance, and only this block drives the timer's addr_bi/data_bi/rd_i/wr_i.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 13, register address width (matches timer addr_bi)
DATA_W, 32, data width (matches timer data_bi/data_bo)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
req_bi  input  NREQ  per-requester request, held high until its ack
we_bi  input  NREQ  per-requester 1=write, 0=read; sampled with request
addr_bi  input  NREQ*ADDR_W  flattened addresses; requester k at [k*ADDR_W +: ADDR_W]
data_bi  input  NREQ*DATA_W  flattened write data, same packing
gnt_bo  output  NREQ  one-hot grant; high from latch until ack cycle inclusive
ack_bo  output  NREQ  one-cycle completion pulse to the granted requester
err_bo  output  1  valid with ack; 1 = address not in {0,4,8}, no timer access made
rdata_bo  output  DATA_W  read data; valid in ack cycle, held until next read completes
busy_o  output  1  high whenever state != IDLE
t_addr_bo  output  ADDR_W  to timer addr_bi
t_data_bo  output  DATA_W  to timer data_bi
t_rd_o  output  1  to timer rd_i
t_wr_o  output  1  to timer wr_i
t_data_bi  input  DATA_W  from timer data_bo (registered in timer, valid the cycle after rd)

Behaviour:
- Reset (async, immediate): state=IDLE; gnt_bo=0, ack_bo=0, err_bo=0, rdata_bo=0, busy_o=0, t_rd_o=0, t_wr_o=0, t_addr_bo=0, t_data_bo=0; RR pointer = requester 0 highest priority.
- All outputs are registered; nothing is combinationally derived from req_bi.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any req_bi, pick the winner by round-robin (search starts at last_granted+1 mod NREQ). Latch its we/addr/data and set gnt_bo one-hot. Next state is ISSUE if the address is valid, else ACK with err pending. No requests: stay in IDLE.
- ISSUE (exactly 1 cycle): t_addr_bo/t_data_bo = latched values; t_wr_o=we, t_rd_o=!we. Next state is ACK for a write, WAIT for a read.
- WAIT (1 cycle): t_rd_o=0; capture t_data_bi into rdata_bo at the closing edge; next state ACK.
- ACK (1 cycle): ack_bo[winner]=1, err_bo per address check, gnt_bo still set. At the closing edge: gnt_bo=0, last_granted=winner, next state IDLE.
- Latency, counting the first cycle req is seen in IDLE as cycle 0: write ack in cycle 2; read ack in cycle 3; invalid address ack (err) in cycle 1.
- Throughput: at least 1 idle cycle between transactions. A requester still high in the cycle after its ack is a new request.
- t_addr_bo/t_data_bo hold their last values outside ISSUE. t_rd_o and t_wr_o are never both high, and each is high at most 1 cycle per transaction.
- Requests that change while granted are ignored; the values latched in IDLE are used.
- Simultaneous requests: only one is granted per transaction. Round-robin guarantees each active requester is served within NREQ transactions.
- Address check: exact compare against 0, 4 and 8; any other value gives err.
- rst mid-transaction aborts without ack. A timer write is done only if ISSUE's closing edge preceded rst, because the timer itself has no reset.

Decomposition:
- Package timer_bus_pkg holds:
  - TMR_ADDR=0, TVAL_ADDR=4, TCONF_ADDR=8
  - the state enum encoding (IDLE/ISSUE/WAIT/ACK)
  - the addr_valid function
- Sub-module rr_arbiter(NREQ): inputs req, last_granted; output one-hot grant plus index; purely combinational pick. The pointer register lives in timer_bus_arbiter.

Test Plan:
- Req0 writes 100 to addr 0 (TMR) → t_wr_o high for exactly cycle 1 with t_addr_bo=0, t_data_bo=100; ack_bo=01 in cycle 2, err=0; timer TMR=100.
- Req1 writes 2 to addr 8 (TCONF), then reads addr 0 → read ack in cycle 3 with rdata_bo=100, err=0; t_rd_o one cycle.
- Req0 and req1 both request continuously from reset → grants alternate 01,10,01,10; acks alternate likewise; no back-to-back grants to one requester.
- Req0 reads addr 12 → ack in cycle 1 with err_bo=1; t_rd_o/t_wr_o stay 0.
- Assert rst in the WAIT cycle of a read → all outputs 0 immediately; no ack; the next request after release is granted to requester 0 first.
- Req1 reads addr 4 (TVAL) while the timer runs incrementing with TMR=100 → rdata_bo equals the timer's TVAL at ISSUE's closing edge, within 0..100.
